// File: rtl/lag_measure_ctrl_pkg.sv
// Shared state encoding and BCD constants for the lag measurement controller.
package lag_measure_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        MEASURE = 2'd2,
        HOLDOFF = 2'd3
    } lag_state_t;

    localparam logic [19:0] DEFAULT_TIMEOUT_BCD = 20'h10000;
    localparam logic [19:0] BCD_INVALID         = 20'h99999;
    localparam int          CLEAR_CYCLES        = 2;

endpackage

// File: rtl/lag_measure_ctrl_if.sv
// Signal bundle between the frame/sensor/counter environment (master) and the controller (slave).
interface lag_measure_ctrl_if;

    logic        start_pulse;
    logic        sensor;
    logic [19:0] bcdcount;
    logic        counter_reset;
    logic        result_valid;
    logic [19:0] result_bcd;
    logic        timeout;
    logic        busy;
    logic [19:0] min_bcd;
    logic [19:0] max_bcd;

    modport master (
        output start_pulse, sensor, bcdcount,
        input  counter_reset, result_valid, result_bcd, timeout, busy, min_bcd, max_bcd
    );

    modport slave (
        input  start_pulse, sensor, bcdcount,
        output counter_reset, result_valid, result_bcd, timeout, busy, min_bcd, max_bcd
    );

endinterface

// File: rtl/lag_measure_ctrl_sensor_debounce.sv
// Two-flop synchronizer for the active-low photo sensor plus a run-length debounce counter.
module sensor_debounce
    import lag_measure_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor,
    input  logic enable,
    output logic light_sync,
    output logic detect
);

    localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEBOUNCE_CYCLES);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] count;

    // Synchronizer idles at 1, which is "dark" for this sensor.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= sensor;
            sync_out  <= sync_meta;
        end
    end

    assign light_sync = ~sync_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || !light_sync) begin
            count <= '0;
        end else if (count != FULL_COUNT) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the sample that completes the run of DEBOUNCE_CYCLES light samples.
    assign detect = enable && light_sync && (count == LAST_COUNT);

endmodule

// File: rtl/lag_measure_ctrl.sv
// Display lag measurement controller: clears an external BCD timer on frame start and latches it on light.
// Optional min/max result tracking is enabled by defining LAG_MIN_MAX_EN.
module lag_measure_ctrl
    import lag_measure_ctrl_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 27,
    parameter logic [19:0] TIMEOUT_BCD     = DEFAULT_TIMEOUT_BCD,
    parameter int          HOLDOFF_FRAMES  = 2
) (
    input  logic             clock,
    input  logic             reset,
    lag_measure_ctrl_if.slave bus
);

    localparam int             HW           = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [HW-1:0]  HOLDOFF_DONE = HW'(HOLDOFF_FRAMES);
    localparam int             CCW          = $clog2(CLEAR_CYCLES);
    localparam logic [CCW-1:0] CLEAR_LAST   = CCW'(CLEAR_CYCLES - 1);

    lag_state_t     state;
    logic [CCW-1:0] clear_cnt;
    logic [HW-1:0]  holdoff_cnt;
    logic           light_sync;
    logic           detect;
    logic           measuring;

    assign measuring = (state == MEASURE);

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .sensor    (bus.sensor),
        .enable    (measuring),
        .light_sync(light_sync),
        .detect    (detect)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            bus.counter_reset <= 1'b0;
            bus.result_valid  <= 1'b0;
            bus.timeout       <= 1'b0;
            bus.busy          <= 1'b0;
            bus.result_bcd    <= '0;
            clear_cnt         <= '0;
            holdoff_cnt       <= '0;
        end else begin
            bus.counter_reset <= 1'b0;
            bus.result_valid  <= 1'b0;
            bus.timeout       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_pulse) begin
                        state             <= CLEAR;
                        bus.counter_reset <= 1'b1;
                        bus.busy          <= 1'b1;
                        clear_cnt         <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_cnt == CLEAR_LAST) begin
                        state <= MEASURE;
                    end else begin
                        clear_cnt <= clear_cnt + CCW'(1);
                    end
                end
                // Detection is tested first so it beats a timeout on the same sample.
                MEASURE: begin
                    if (detect) begin
                        bus.result_bcd   <= bus.bcdcount;
                        bus.result_valid <= 1'b1;
                        state            <= HOLDOFF;
                        holdoff_cnt      <= '0;
                    end else if (bus.bcdcount >= TIMEOUT_BCD) begin
                        bus.result_bcd <= BCD_INVALID;
                        bus.timeout    <= 1'b1;
                        state          <= HOLDOFF;
                        holdoff_cnt    <= '0;
                    end
                end
                HOLDOFF: begin
                    if ((holdoff_cnt == HOLDOFF_DONE) && !light_sync) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (bus.start_pulse && (holdoff_cnt != HOLDOFF_DONE)) begin
                        holdoff_cnt <= holdoff_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef LAG_MIN_MAX_EN
    // Extremes move with the detection sample so they change on the result_valid cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.min_bcd <= BCD_INVALID;
            bus.max_bcd <= '0;
        end else if (detect) begin
            if (bus.bcdcount < bus.min_bcd) begin
                bus.min_bcd <= bus.bcdcount;
            end
            if (bus.bcdcount > bus.max_bcd) begin
                bus.max_bcd <= bus.bcdcount;
            end
        end
    end
`else
    assign bus.min_bcd = '0;
    assign bus.max_bcd = '0;
`endif

endmodule

// File: doc/lag_measure_ctrl.md
LAG_MEASURE_CTRL -- requirements
Module: lag_measure_ctrl

Interface
REQ-001 Parameters SHALL be:
- DEBOUNCE_CYCLES, default 27: consecutive active sensor samples needed to declare detection (1 us at 27 MHz).
- TIMEOUT_BCD, default 20'h10000: bcdcount value (100.00 ms) at which a measurement aborts.
- HOLDOFF_FRAMES, default 2: start pulses ignored after each result.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clock  in  1  27 MHz system clock.
- reset  in  1  synchronous active-high reset.
- start_pulse  in  1  one-cycle frame-start flag, already crossed into clock domain.
- sensor  in  1  raw asynchronous photo sensor, active-low (0 = light).
- bcdcount  in  20  5-digit BCD elapsed time, 0.01 ms units.
- counter_reset  out  1  one-cycle clear request to the BCD counter.
- result_valid  out  1  one-cycle strobe with result_bcd.
- result_bcd  out  20  latched lag measurement.
- timeout  out  1  one-cycle strobe on aborted measurement.
- busy  out  1  high in every state except IDLE.
- min_bcd  out  20  smallest result (macro only).
- max_bcd  out  20  largest result (macro only).

Function
REQ-004 sensor SHALL pass a 2-flop synchronizer; the synchronized value is inverted to form light_sync.
REQ-005 The FSM states SHALL be IDLE, CLEAR, MEASURE, HOLDOFF.
REQ-006 IDLE: start_pulse SHALL assert counter_reset on the next cycle and move to CLEAR.
REQ-007 CLEAR SHALL last exactly 2 cycles, then go to MEASURE; bcdcount is not evaluated in CLEAR.
REQ-008 MEASURE: a debounce counter SHALL increment while light_sync=1 and clear to 0 when light_sync=0.
REQ-009 When the debounce count reaches DEBOUNCE_CYCLES, the block SHALL latch bcdcount into result_bcd, pulse result_valid on the following cycle, and enter HOLDOFF.
REQ-010 In MEASURE, bcdcount >= TIMEOUT_BCD SHALL pulse timeout, set result_bcd to 20'h99999, and enter HOLDOFF.
REQ-011 BCD comparisons SHALL be plain unsigned 20-bit compares; packed BCD ordering equals binary ordering.
REQ-012 If detection and timeout occur in the same cycle, detection SHALL win and timeout stays low.
REQ-013 HOLDOFF SHALL count start_pulse events.
REQ-014 HOLDOFF SHALL return to IDLE only when HOLDOFF_FRAMES pulses have been counted and light_sync=0; it stays in HOLDOFF while light persists.
REQ-015 start_pulse outside IDLE SHALL be ignored, except that it counts in HOLDOFF.
REQ-016 result_bcd SHALL hold its value until the next result or timeout.

Reset
REQ-017 Reset SHALL force the FSM to IDLE from any state within one cycle, aborting any measurement without strobes.
REQ-018 Reset values SHALL be:
- counter_reset=0, result_valid=0, timeout=0, busy=0, result_bcd=0.
- Debounce and holdoff counters: 0.
- Synchronizer flops: 1 (dark).

Configuration
REQ-019 With LAG_MIN_MAX_EN defined:
- min_bcd SHALL reset to 20'h99999 and max_bcd to 0.
- Each valid result SHALL update them on the result_valid cycle.
- Timeouts SHALL never update them.
REQ-020 Without LAG_MIN_MAX_EN, min_bcd and max_bcd SHALL be tied to 0 and no tracking logic SHALL be present.

Structure
REQ-021 A shared package SHALL hold the state enum, the default TIMEOUT_BCD constant and the BCD "invalid" value 20'h99999.
REQ-022 The synchronizer plus debounce counter SHALL be one sub-module, sensor_debounce.

Verification
REQ-023 Basic detection: start_pulse, bcdcount ramp, sensor low when bcdcount=20'h01234 -> result_valid once, result_bcd=20'h01234 (+ debounce/sync latency), busy high throughout.
REQ-024 Debounce reject: sensor low for 20 cycles, then high, in MEASURE -> no result; a later 27-cycle low -> result.
REQ-025 Timeout: no sensor activity, bcdcount reaches 20'h10000 -> timeout pulse, result_bcd=20'h99999, min/max unchanged.
REQ-026 Simultaneous: debounce completes on the cycle bcdcount=20'h10000 -> result_valid=1, timeout=0.
REQ-027 Holdoff: sensor held low after detection through 3 start pulses -> remains HOLDOFF; sensor high plus next pulse -> IDLE; a start_pulse during MEASURE -> no counter_reset.
REQ-028 Reset mid-MEASURE: reset asserted -> next cycle IDLE, all strobes 0. With LAG_MIN_MAX_EN: results 20'h00500 then 20'h00300 -> min 20'h00300, max 20'h00500.
